// File: rtl/serial_add_arbiter_pkg.sv
// Shared definitions for the serial adder arbiter.
// Holds the FSM state encodings, default operand width and timeout, the timer width and a helper
// that sizes requester-id fields (minimum one bit).
package serial_add_arbiter_pkg;

  localparam int unsigned DefWidth   = 32;
  localparam int unsigned DefTimeout = 63;
  localparam int unsigned TimerW     = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_add_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req_i starting at index ptr_i, wrapping modulo NREQ, and returns the first set bit.
// Ports:
//   req_i        request vector, one bit per requester
//   ptr_i        index with highest priority this round (must be < NREQ)
//   gnt_o        one-hot grant (all zero when no request)
//   gnt_idx_o    index of the granted requester
//   gnt_valid_o  1 when any request is granted
module serial_add_arbiter_rr_arbiter
  import serial_add_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IdW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdW-1:0]  gnt_idx_o,
  output logic            gnt_valid_o
);

  logic [IdW-1:0] idx;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = IdW'((32'(ptr_i) + off) % NREQ);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/serial_add_arbiter.sv
// Shares one bit-serial adder core between NREQ requesters.
// Grants one request at a time round-robin, launches the adder with a one-cycle start pulse, waits
// for its done (or a timeout) and returns the result tagged with the requester id.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/ready_o    per-requester handshake; ready is one-hot and only raised in IDLE
//   req_a_i, req_b_i       packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin_i              per-requester carry-in
//   rsp_valid_o/ready_i    result handshake
//   rsp_id_o, rsp_sum_o,
//   rsp_cout_o, rsp_err_o  result fields; err=1 means the adder timed out (sum/cout forced 0)
//   add_start_o            one-cycle start pulse to the adder
//   add_a_o, add_b_o,
//   add_cin_o              adder operands, held from ISSUE through WAIT
//   add_done_i, add_sum_i,
//   add_cout_i             adder completion and result; done outside WAIT is ignored
module serial_add_arbiter
  import serial_add_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned TIMEOUT = DefTimeout,
  localparam int unsigned IdW    = id_width(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  input  logic [NREQ-1:0]   req_cin_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IdW-1:0]    rsp_id_o,
  output logic [WIDTH-1:0]  rsp_sum_o,
  output logic              rsp_cout_o,
  output logic              rsp_err_o,
  output logic              add_start_o,
  output logic [WIDTH-1:0]  add_a_o,
  output logic [WIDTH-1:0]  add_b_o,
  output logic              add_cin_o,
  input  logic              add_done_i,
  input  logic [WIDTH-1:0]  add_sum_i,
  input  logic              add_cout_i
);

  logic [1:0]        state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              cin_q, cin_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;

  logic [NREQ-1:0]   gnt;
  logic [IdW-1:0]    gnt_idx;
  logic              gnt_valid;

  serial_add_arbiter_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    timer_d = timer_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // A grant in IDLE is the handshake, since req_ready mirrors the grant here.
        if (gnt_valid) begin
          a_d     = req_a_i[32'(gnt_idx)*WIDTH +: WIDTH];
          b_d     = req_b_i[32'(gnt_idx)*WIDTH +: WIDTH];
          cin_d   = req_cin_i[gnt_idx];
          id_d    = gnt_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over a timeout landing in the same cycle
        if (add_done_i) begin
          sum_d   = add_sum_i;
          cout_d  = add_cout_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        if (rsp_ready_i) begin
          ptr_d   = (id_q == IdW'(NREQ - 1)) ? '0 : id_q + IdW'(1);
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      timer_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      timer_q <= timer_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  // Ready is masked during reset so no requester sees a grant that reset will discard.
  assign req_ready_o = (state_q == ST_IDLE && !rst_i) ? gnt : '0;
  assign add_start_o = (state_q == ST_ISSUE);
  assign add_a_o     = a_q;
  assign add_b_o     = b_q;
  assign add_cin_o   = cin_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_id_o    = id_q;
  assign rsp_sum_o   = sum_q;
  assign rsp_cout_o  = cout_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
module tb_serial_add_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [1:0]  req_cin = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_err;
  logic        add_start;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic        add_done = 1'b0;
  logic [31:0] add_sum = '0;
  logic        add_cout = 1'b0;

  int total = 0;
  int bad = 0;
  int lat = 3;
  bit model_en = 1'b1;

  serial_add_arbiter #(
    .NREQ    (2),
    .WIDTH   (32),
    .TIMEOUT (63)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_cin_i   (req_cin),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .rsp_cout_o  (rsp_cout),
    .rsp_err_o   (rsp_err),
    .add_start_o (add_start),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_cin_o   (add_cin),
    .add_done_i  (add_done),
    .add_sum_i   (add_sum),
    .add_cout_i  (add_cout)
  );

  always #5 clk = ~clk;

  // Adder stand-in: done pulse lat+1 cycles after start; ignores rst so late dones can occur.
  bit busy = 1'b0;
  int cnt = 0;
  always @(posedge clk) begin
    add_done <= 1'b0;
    if (add_start) begin
      busy <= 1'b1;
      cnt  <= lat;
    end else if (busy) begin
      if (cnt == 0) begin
        busy <= 1'b0;
        if (model_en) begin
          add_done <= 1'b1;
          {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
        end
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise valid for idx, wait for the handshake, return at the ISSUE-cycle negedge.
  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    bit ok;
    ok = 1'b0;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_cin[idx] = cin;
    req_valid[idx] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL grant_wait: requester %0d got no req_ready, wanted a grant", idx);
    end
    @(negedge clk);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, wanted 1", rsp_valid, cyc);
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b01;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00) begin
      bad++; $display("FAIL rst_req_ready: got %b want 00", req_ready);
    end
    total++;
    if ({rsp_valid, add_start, rsp_err, rsp_cout, add_cin} !== 5'b0) begin
      bad++; $display("FAIL rst_flags: got %b want 00000",
                      {rsp_valid, add_start, rsp_err, rsp_cout, add_cin});
    end
    total++;
    if ({rsp_sum, add_a, add_b, rsp_id} !== 97'b0) begin
      bad++; $display("FAIL rst_data: got %h want 0", {rsp_sum, add_a, add_b, rsp_id});
    end
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    req_a[31:0] = 32'h0000_0005;
    req_b[31:0] = 32'h0000_0003;
    req_cin[0] = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL basic_ready: got %b want 01", req_ready);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    total++;
    if (add_start !== 1'b1 || add_a !== 32'd5 || add_b !== 32'd3 || add_cin !== 1'b0) begin
      bad++; $display("FAIL basic_issue: start=%b a=%h b=%h cin=%b want 1 5 3 0",
                      add_start, add_a, add_b, add_cin);
    end
    @(negedge clk);
    total++;
    if (add_start !== 1'b0) begin
      bad++; $display("FAIL basic_start_pulse: got %b want 0", add_start);
    end
    wait_rsp(cyc);
    total++;
    if (rsp_id !== 1'b0 || rsp_sum !== 32'd8 || rsp_cout !== 1'b0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL basic_rsp: id=%0d sum=%h cout=%b err=%b want 0 8 0 0",
                      rsp_id, rsp_sum, rsp_cout, rsp_err);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL basic_rsp_drop: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_carry();
    int cyc;
    issue(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    wait_rsp(cyc);
    total++;
    if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL carry_out: sum=%h cout=%b err=%b want 0 1 0",
                      rsp_sum, rsp_cout, rsp_err);
    end
    @(negedge clk);
    issue(1, 32'h0, 32'h0, 1'b1);
    wait_rsp(cyc);
    total++;
    if (rsp_sum !== 32'h1 || rsp_cout !== 1'b0 || rsp_id !== 1'b1) begin
      bad++; $display("FAIL carry_in: sum=%h cout=%b id=%0d want 1 0 1",
                      rsp_sum, rsp_cout, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [0:0] exp_id;
    logic [31:0] exp_sum;
    do_reset();
    req_a = {32'd20, 32'd10};
    req_b = {32'd2, 32'd1};
    req_cin = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_id  = (k % 2 == 0) ? 1'b0 : 1'b1;
      exp_sum = (k % 2 == 0) ? 32'd11 : 32'd22;
      wait_rsp(cyc);
      total++;
      if (rsp_id !== exp_id || rsp_sum !== exp_sum) begin
        bad++; $display("FAIL rr_order[%0d]: id=%0d sum=%0d want %0d %0d",
                        k, rsp_id, rsp_sum, exp_id, exp_sum);
      end
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    model_en = 1'b0;
    issue(0, 32'h55, 32'h11, 1'b0);
    wait_rsp(cyc);
    total++;
    if (cyc != 64) begin
      bad++; $display("FAIL timeout_cycles: got %0d want 64", cyc);
    end
    total++;
    if (rsp_err !== 1'b1 || rsp_sum !== 32'h0 || rsp_cout !== 1'b0) begin
      bad++; $display("FAIL timeout_rsp: err=%b sum=%h cout=%b want 1 0 0",
                      rsp_err, rsp_sum, rsp_cout);
    end
    @(negedge clk);
    model_en = 1'b1;
    issue(0, 32'd7, 32'd8, 1'b0);
    wait_rsp(cyc);
    total++;
    if (rsp_err !== 1'b0 || rsp_sum !== 32'd15 || rsp_id !== 1'b0) begin
      bad++; $display("FAIL timeout_recover: err=%b sum=%0d id=%0d want 0 15 0",
                      rsp_err, rsp_sum, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    rsp_ready = 1'b0;
    issue(0, 32'd100, 32'd23, 1'b0);
    wait_rsp(cyc);
    req_a[63:32] = 32'd1;
    req_b[63:32] = 32'd1;
    req_cin[1] = 1'b0;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'd123 || rsp_id !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: valid=%b sum=%0d id=%0d want 1 123 0",
                        i, rsp_valid, rsp_sum, rsp_id);
      end
      total++;
      if (add_start !== 1'b0 || req_ready !== 2'b00) begin
        bad++; $display("FAIL bp_idle[%0d]: start=%b ready=%b want 0 00",
                        i, add_start, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
      bad++; $display("FAIL bp_release: valid=%b ready=%b want 0 10", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp(cyc);
    total++;
    if (rsp_id !== 1'b1 || rsp_sum !== 32'd2) begin
      bad++; $display("FAIL bp_next: id=%0d sum=%0d want 1 2", rsp_id, rsp_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    lat = 20;
    issue(1, 32'h1234, 32'h1, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({rsp_valid, add_start, rsp_err, rsp_cout, add_cin} !== 5'b0) begin
      bad++; $display("FAIL midrst_flags: got %b want 00000",
                      {rsp_valid, add_start, rsp_err, rsp_cout, add_cin});
    end
    total++;
    if (add_a !== 32'h0 || add_b !== 32'h0 || rsp_sum !== 32'h0 || rsp_id !== 1'b0) begin
      bad++; $display("FAIL midrst_data: a=%h b=%h sum=%h id=%0d want 0 0 0 0",
                      add_a, add_b, rsp_sum, rsp_id);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL midrst_no_rsp: rsp_valid seen=1 want 0");
    end
    lat = 3;
    issue(1, 32'd1, 32'd2, 1'b1);
    wait_rsp(cyc);
    total++;
    if (rsp_id !== 1'b1 || rsp_sum !== 32'd4 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL midrst_next: id=%0d sum=%0d err=%b want 1 4 0",
                      rsp_id, rsp_sum, rsp_err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
